allot_doctor_pool: RTL and testbench
====================================

Name: allot_doctor_pool

Overview:
- Parametrised successor to the two-doctor allotter for the reception desk.
- Manages a pool of N_DOC doctors, each with a fixed consultation timer and an early-release input.
- Each incoming patient request carries an eligibility mask. The block grants the lowest-index free eligible doctor, or rejects the request (or queues it, with WAIT_QUEUE_EN).
- Sits between the query decoder and the display/message driver.

Parameters:
- N_DOC, 4: number of doctors; valid range 1..16.
- CONSULT_CYC, 15: cycles a doctor stays busy after allocation; minimum 2.
- TAG_W, 4: width of the patient tag echoed in responses.
- WAIT_DEPTH, 4: waiting-queue entries; used only with WAIT_QUEUE_EN; power of two.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  patient request present.
- req_ready  out  1  block can accept a request this cycle.
- req_mask  in  N_DOC  bit i = doctor i is eligible for this patient.
- req_tag  in  TAG_W  patient identifier.
- release  in  N_DOC  bit i pulses to end doctor i's consultation early.
- resp_valid  out  1  one-cycle pulse: outcome of an accepted request.
- resp_status  out  2  00 none, 01 ALLOC, 10 QUEUED, 11 REJECT.
- resp_doc  out  clog2(N_DOC) (min 1)  allocated doctor index; 0 unless ALLOC.
- resp_tag  out  TAG_W  echo of the accepted req_tag.
- alloc_valid  out  1  one-cycle pulse: deferred allocation from the queue.
- alloc_doc  out  clog2(N_DOC)  doctor granted to the queue head.
- alloc_tag  out  TAG_W  tag of the dequeued patient.
- busy  out  N_DOC  registered per-doctor busy flags.
- q_count  out  clog2(WAIT_DEPTH)+1  queue occupancy; 0 without WAIT_QUEUE_EN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - busy, all counters, resp_*, alloc_*, q_count and queue pointers go to 0.
  - req_ready drives 1 from the first edge after reset release.
- Accept rule: a request is accepted on an edge where req_valid && req_ready.
- Response timing:
  - resp_* are registered; resp_valid pulses exactly one cycle after acceptance.
  - Without acceptance, resp_valid = 0 and resp_status = 00.
- Free vector used for the grant: free = ~busy & ~release, taken after any queue grant made in the same cycle.
- Grant rule:
  - If req_mask & free is non-zero, grant the lowest-index set bit and report ALLOC.
  - If req_mask is zero, report REJECT with resp_doc = 0.
  - If no eligible doctor is free: REJECT without the queue feature; otherwise see Optional Feature.
- Doctor timer, per doctor:
  - On grant: busy <= 1, cnt <= 0.
  - While busy: cnt increments each cycle.
  - At cnt == CONSULT_CYC-1: busy <= 0.
  - Net effect: busy is high for exactly CONSULT_CYC cycles after the grant edge.
  - The doctor can be re-granted in the cycle busy reads 0.
- release[i]:
  - Ignored when doctor i is idle.
  - When doctor i is busy: clears busy and cnt on the next edge.
  - The doctor is not grantable in the release cycle itself.
- Concurrency:
  - Different doctors are independent.
  - A queue grant and a new-request grant in the same cycle never pick the same doctor; the queue wins.
- Reset mid-consultation aborts every timer; no response is emitted for the aborted state.
- Counter width: clog2(CONSULT_CYC); no wrap, since cnt never exceeds CONSULT_CYC-1.

Optional Feature:
- Macro: WAIT_QUEUE_EN.
- Defined:
  - A WAIT_DEPTH-entry FIFO stores {mask, tag}.
  - A request with a non-zero mask and no free eligible doctor is enqueued and reported as QUEUED.
  - Each cycle the head is checked first: if head mask & free is non-zero, the head is dequeued, the lowest-index eligible doctor is granted, and alloc_* pulse on the next cycle.
  - Service is head-of-line only; later entries never bypass the head.
  - req_ready = 0 when the queue is full, except when a dequeue happens that same cycle.
  - A zero-mask request is still REJECT.
- Not defined: no FIFO; alloc_valid = 0, q_count = 0, req_ready = 1; busy-eligible requests are REJECT.

Test Plan:
- Reset, then request mask=4'b0011, tag=5 → next cycle resp ALLOC doc=0 tag=5; busy=0001 for exactly 15 cycles.
- Doctors 0 and 1 busy, request mask=4'b0111 → ALLOC doc=2; request mask=4'b0011 → REJECT (no queue).
- Request mask=0 → REJECT, resp_doc=0; busy unchanged.
- Doctor 1 busy, release[1] pulsed at cycle 3 → busy[1]=0 the next cycle; request mask=4'b0010 two cycles later → ALLOC doc=1; release to an idle doctor → no change.
- WAIT_QUEUE_EN, doctor 0 busy, two requests mask=4'b0001 with tags 1 and 2 → both QUEUED, q_count=2. Doctor 0 expires → alloc tag=1 doc=0, then after another 15 cycles alloc tag=2.
- WAIT_QUEUE_EN, fill 4 queue entries → req_ready=0; a fifth request is held off. Assert rst_n low mid-run → everything clears asynchronously and q_count=0.

Source files
------------

// File: rtl/allot_doctor_pool.sv
`default_nettype none
//============================================================================
// Module   : allot_doctor_pool
// Brief    : Reception-desk allotter for a pool of N_DOC doctors. Each
//            request carries an eligibility mask. The block grants the
//            lowest-index free eligible doctor. Each doctor stays busy for
//            CONSULT_CYC cycles, or until an early release.
// Options  : WAIT_QUEUE_EN - adds a WAIT_DEPTH-entry head-of-line waiting
//            queue. Requests that find no free eligible doctor are queued
//            instead of rejected.
// Revision : 1.0 - initial parametrised pool
//============================================================================
module allot_doctor_pool #(
  parameter int N_DOC       = 4,
  parameter int CONSULT_CYC = 15,
  parameter int TAG_W       = 4,
  parameter int WAIT_DEPTH  = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         req_valid,
  output logic                                         req_ready,
  input  logic [N_DOC-1:0]                             req_mask,
  input  logic [TAG_W-1:0]                             req_tag,
  // Early-release pulses, one per doctor ("release" is a reserved word)
  input  logic [N_DOC-1:0]                             doc_release,
  output logic                                         resp_valid,
  output logic [1:0]                                   resp_status,
  output logic [((N_DOC > 1) ? $clog2(N_DOC) : 1)-1:0] resp_doc,
  output logic [TAG_W-1:0]                             resp_tag,
  output logic                                         alloc_valid,
  output logic [((N_DOC > 1) ? $clog2(N_DOC) : 1)-1:0] alloc_doc,
  output logic [TAG_W-1:0]                             alloc_tag,
  output logic [N_DOC-1:0]                             busy,
  output logic [$clog2(WAIT_DEPTH):0]                  q_count
);

  localparam int c_doc_w = (N_DOC > 1) ? $clog2(N_DOC) : 1;
  localparam int c_cnt_w = (CONSULT_CYC > 1) ? $clog2(CONSULT_CYC) : 1;
  localparam int c_qc_w  = $clog2(WAIT_DEPTH) + 1;

  localparam logic [1:0] c_st_alloc  = 2'b01;
  localparam logic [1:0] c_st_queued = 2'b10;
  localparam logic [1:0] c_st_reject = 2'b11;
`ifdef WAIT_QUEUE_EN
  localparam logic [1:0] c_st_miss   = c_st_queued;
`else
  localparam logic [1:0] c_st_miss   = c_st_reject;
`endif

  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CONSULT_CYC - 1);

  // Index of the lowest set bit (0 when the vector is empty)
  function automatic logic [c_doc_w-1:0] f_lowest_idx(input logic [N_DOC-1:0] v);
    logic [c_doc_w-1:0] idx;
    idx = '0;
    for (int i = N_DOC - 1; i >= 0; i--) begin
      if (v[i]) idx = c_doc_w'(i);
    end
    return idx;
  endfunction

  // One-hot of the lowest set bit
  function automatic logic [N_DOC-1:0] f_lowest_oh(input logic [N_DOC-1:0] v);
    return v & (~v + N_DOC'(1));
  endfunction

  logic             r_ready_en;
  logic [N_DOC-1:0] w_free_base;
  logic [N_DOC-1:0] w_free_req;
  logic [N_DOC-1:0] w_q_grant_oh;
  logic             w_deq;
  logic [N_DOC-1:0] w_req_cand;
  logic             w_req_hit;
  logic [N_DOC-1:0] w_req_oh;
  logic [c_doc_w-1:0] w_req_doc;
  logic             w_accept;
  logic [N_DOC-1:0] w_grant;

  // A doctor in its release cycle is not grantable. The queue head is served
  // first, so a new request only sees doctors the head did not take.
  assign w_free_base = ~busy & ~doc_release;
  assign w_free_req  = w_free_base & ~w_q_grant_oh;
  assign w_req_cand  = req_mask & w_free_req;
  assign w_req_hit   = |w_req_cand;
  assign w_req_oh    = f_lowest_oh(w_req_cand);
  assign w_req_doc   = f_lowest_idx(w_req_cand);
  assign w_accept    = req_valid & req_ready;
  assign w_grant     = w_q_grant_oh | ((w_accept && w_req_hit) ? w_req_oh : '0);

  // Ready comes up on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ready_en <= 1'b0;
    else        r_ready_en <= 1'b1;
  end

`ifdef WAIT_QUEUE_EN
  localparam int c_ptr_w = (WAIT_DEPTH > 1) ? $clog2(WAIT_DEPTH) : 1;

  logic [N_DOC-1:0]   r_q_mask [WAIT_DEPTH];
  logic [TAG_W-1:0]   r_q_tag  [WAIT_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_qc_w-1:0]  r_q_count;
  logic               w_q_empty;
  logic               w_q_full;
  logic [N_DOC-1:0]   w_head_hit;
  logic [c_doc_w-1:0] w_q_doc;
  logic [TAG_W-1:0]   w_q_tag;
  logic               w_enq;
  logic               r_alloc_valid;
  logic [c_doc_w-1:0] r_alloc_doc;
  logic [TAG_W-1:0]   r_alloc_tag;

  assign w_q_empty    = (r_q_count == '0);
  assign w_q_full     = (r_q_count == c_qc_w'(WAIT_DEPTH));
  assign w_head_hit   = w_q_empty ? '0 : (r_q_mask[r_rd_ptr] & w_free_base);
  assign w_deq        = |w_head_hit;
  assign w_q_grant_oh = f_lowest_oh(w_head_hit);
  assign w_q_doc      = f_lowest_idx(w_head_hit);
  assign w_q_tag      = r_q_tag[r_rd_ptr];
  assign w_enq        = w_accept & (|req_mask) & ~w_req_hit;

  // A full queue still accepts when the head leaves in the same cycle
  assign req_ready    = r_ready_en & (~w_q_full | w_deq);
  assign q_count      = r_q_count;
  assign alloc_valid  = r_alloc_valid;
  assign alloc_doc    = r_alloc_doc;
  assign alloc_tag    = r_alloc_tag;

  // Queue storage; contents are qualified by the occupancy count
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_mask[r_wr_ptr] <= req_mask;
      r_q_tag[r_wr_ptr]  <= req_tag;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_q_count <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= (r_wr_ptr == c_ptr_w'(WAIT_DEPTH - 1)) ? '0 : r_wr_ptr + c_ptr_w'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_w'(WAIT_DEPTH - 1)) ? '0 : r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_q_count <= r_q_count + c_qc_w'(1);
        2'b01:   r_q_count <= r_q_count - c_qc_w'(1);
        default: r_q_count <= r_q_count;
      endcase
    end
  end

  // Deferred-allocation pulse for the dequeued head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc_valid <= 1'b0;
      r_alloc_doc   <= '0;
      r_alloc_tag   <= '0;
    end else begin
      r_alloc_valid <= w_deq;
      r_alloc_doc   <= w_deq ? w_q_doc : '0;
      r_alloc_tag   <= w_deq ? w_q_tag : '0;
    end
  end
`else
  assign w_deq        = 1'b0;
  assign w_q_grant_oh = '0;
  assign req_ready    = r_ready_en;
  assign q_count      = '0;
  assign alloc_valid  = 1'b0;
  assign alloc_doc    = '0;
  assign alloc_tag    = '0;
`endif

  // Registered response for every accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_status <= 2'b00;
      resp_doc    <= '0;
      resp_tag    <= '0;
    end else begin
      resp_valid <= w_accept;
      if (w_accept) begin
        resp_tag <= req_tag;
        if (req_mask == '0) begin
          resp_status <= c_st_reject;
          resp_doc    <= '0;
        end else if (w_req_hit) begin
          resp_status <= c_st_alloc;
          resp_doc    <= w_req_doc;
        end else begin
          resp_status <= c_st_miss;
          resp_doc    <= '0;
        end
      end else begin
        resp_status <= 2'b00;
        resp_doc    <= '0;
        resp_tag    <= '0;
      end
    end
  end

  // Per-doctor consultation timers
  for (genvar i = 0; i < N_DOC; i++) begin : g_doc
    logic               r_busy;
    logic [c_cnt_w-1:0] r_cnt;

    assign busy[i] = r_busy;

    // Busy for exactly CONSULT_CYC cycles after the grant edge, or until released
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else if (w_grant[i]) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
      end else if (r_busy) begin
        if (doc_release[i] || (r_cnt == c_last)) begin
          r_busy <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_allot_doctor_pool.sv
`default_nettype none
//============================================================================
// Module   : tb_allot_doctor_pool
// Brief    : Self-checking bench for allot_doctor_pool. It holds a
//            remaining-time model of every doctor and the waiting line, and
//            compares against the DUT each cycle. Directed literal checks
//            cover the key points of the behaviour.
// Options  : WAIT_QUEUE_EN - also exercises the waiting queue
// Revision : 1.0 - initial bench
//============================================================================
module tb_allot_doctor_pool;

  localparam int N_DOC       = 4;
  localparam int CONSULT_CYC = 15;
  localparam int TAG_W       = 4;
  localparam int WAIT_DEPTH  = 4;
  localparam int DW          = 2;
  localparam int QW          = 3;
`ifdef WAIT_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif
  localparam logic [1:0] ST_MISS = QEN ? 2'b10 : 2'b11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [N_DOC-1:0] req_mask;
  logic [TAG_W-1:0] req_tag;
  logic [N_DOC-1:0] doc_release;
  logic             resp_valid;
  logic [1:0]       resp_status;
  logic [DW-1:0]    resp_doc;
  logic [TAG_W-1:0] resp_tag;
  logic             alloc_valid;
  logic [DW-1:0]    alloc_doc;
  logic [TAG_W-1:0] alloc_tag;
  logic [N_DOC-1:0] busy;
  logic [QW-1:0]    q_count;

  int n_chk = 0;
  int n_err = 0;

  allot_doctor_pool #(
    .N_DOC(N_DOC), .CONSULT_CYC(CONSULT_CYC), .TAG_W(TAG_W), .WAIT_DEPTH(WAIT_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_mask(req_mask), .req_tag(req_tag), .doc_release(doc_release),
    .resp_valid(resp_valid), .resp_status(resp_status), .resp_doc(resp_doc),
    .resp_tag(resp_tag), .alloc_valid(alloc_valid), .alloc_doc(alloc_doc),
    .alloc_tag(alloc_tag), .busy(busy), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [N_DOC-1:0] mask;
    logic [TAG_W-1:0] tag;
  } qent_t;

  int         rem [N_DOC];     // cycles of consultation left per doctor
  bit         ready_en = 1'b0;
  qent_t      mq[$];
  logic       m_resp_valid = 1'b0;
  logic [1:0] m_resp_status = 2'b00;
  int         m_resp_doc = 0;
  int         m_resp_tag = 0;
  logic       m_alloc_valid = 1'b0;
  int         m_alloc_doc = 0;
  int         m_alloc_tag = 0;

  function automatic int lowest(input logic [N_DOC-1:0] v);
    for (int i = 0; i < N_DOC; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [N_DOC-1:0] m_busy();
    logic [N_DOC-1:0] b;
    for (int i = 0; i < N_DOC; i++) b[i] = (rem[i] > 0);
    return b;
  endfunction

  function automatic bit m_ready();
    logic [N_DOC-1:0] f;
    if (!ready_en) return 1'b0;
    if (!QEN || mq.size() < WAIT_DEPTH) return 1'b1;
    f = ~m_busy() & ~doc_release;
    return (mq[0].mask & f) != '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_DOC; i++) rem[i] = 0;
    mq.delete();
    ready_en = 1'b0;
    m_resp_valid = 1'b0; m_resp_status = 2'b00; m_resp_doc = 0; m_resp_tag = 0;
    m_alloc_valid = 1'b0; m_alloc_doc = 0; m_alloc_tag = 0;
  endtask

  task automatic model_step();
    logic [N_DOC-1:0] free, grants;
    bit rdy;
    int d;
    free = ~m_busy() & ~doc_release;
    grants = '0;
    rdy = m_ready();
    m_alloc_valid = 1'b0; m_alloc_doc = 0; m_alloc_tag = 0;
    if (QEN && mq.size() > 0 && (mq[0].mask & free) != '0) begin
      d = lowest(mq[0].mask & free);
      grants[d] = 1'b1;
      free[d] = 1'b0;
      m_alloc_valid = 1'b1; m_alloc_doc = d; m_alloc_tag = mq[0].tag;
      void'(mq.pop_front());
    end
    m_resp_valid = 1'b0; m_resp_status = 2'b00; m_resp_doc = 0; m_resp_tag = 0;
    if (req_valid && rdy) begin
      m_resp_valid = 1'b1;
      m_resp_tag = req_tag;
      if (req_mask == '0) begin
        m_resp_status = 2'b11;
      end else if ((req_mask & free) != '0) begin
        d = lowest(req_mask & free);
        grants[d] = 1'b1;
        m_resp_status = 2'b01;
        m_resp_doc = d;
      end else if (QEN) begin
        mq.push_back('{mask: req_mask, tag: req_tag});
        m_resp_status = 2'b10;
      end else begin
        m_resp_status = 2'b11;
      end
    end
    for (int i = 0; i < N_DOC; i++) begin
      if (grants[i]) rem[i] = CONSULT_CYC;
      else if (rem[i] > 0) rem[i] = doc_release[i] ? 0 : rem[i] - 1;
    end
    ready_en = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Cycle-by-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("busy", busy, m_busy());
    chk("req_ready", req_ready, m_ready());
    chk("resp_valid", resp_valid, m_resp_valid);
    chk("resp_status", resp_status, m_resp_status);
    chk("resp_doc", resp_doc, m_resp_doc);
    chk("resp_tag", resp_tag, m_resp_tag);
    chk("alloc_valid", alloc_valid, m_alloc_valid);
    chk("alloc_doc", alloc_doc, m_alloc_doc);
    chk("alloc_tag", alloc_tag, m_alloc_tag);
    chk("q_count", q_count, mq.size());
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N_DOC-1:0] m, input logic [TAG_W-1:0] t);
    req_valid = 1'b1; req_mask = m; req_tag = t;
    tick();
    req_valid = 1'b0; req_mask = '0; req_tag = '0;
  endtask

  task automatic expect_resp(input string nm, input logic [1:0] st, input int doc, input int tag);
    chk({nm, "_valid"}, resp_valid, 1);
    chk({nm, "_status"}, resp_status, st);
    chk({nm, "_doc"}, resp_doc, doc);
    chk({nm, "_tag"}, resp_tag, tag);
  endtask

  // Waits (bounded) for the next deferred allocation; returns ticks spent
  task automatic wait_alloc(output int n);
    n = 0;
    while (!alloc_valid && n < 60) begin
      tick();
      n++;
    end
    chk("alloc_seen", alloc_valid, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b1; req_valid = 1'b0; req_mask = '0; req_tag = '0; doc_release = '0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1'b1;
    chk("ready_before_edge", req_ready, 0);
    tick();
    chk("ready_after_edge", req_ready, 1);

    // First grant and exact busy length
    send(4'b0011, 4'd5);
    expect_resp("first", 2'b01, 0, 5);
    chk("first_busy", busy, 4'b0001);
    repeat (14) tick();
    chk("busy_cycle15", busy, 4'b0001);
    tick();
    chk("busy_cycle16", busy, 4'b0000);

    // Several doctors busy
    send(4'b0001, 4'd1);
    expect_resp("d0", 2'b01, 0, 1);
    send(4'b0010, 4'd2);
    expect_resp("d1", 2'b01, 1, 2);
    send(4'b0111, 4'd3);
    expect_resp("d2", 2'b01, 2, 3);
    send(4'b0011, 4'd4);
    expect_resp("miss", ST_MISS, 0, 4);
    send(4'b0000, 4'd7);
    expect_resp("zero_mask", 2'b11, 0, 7);
    chk("zero_mask_busy", busy, 4'b0111);
    repeat (50) tick();

    // Re-grant boundary: rejected on the last busy cycle, granted once busy reads 0
    send(4'b0001, 4'd8);
    expect_resp("rg_first", 2'b01, 0, 8);
    repeat (14) tick();
    send(4'b0001, 4'd9);
    expect_resp("rg_busy", ST_MISS, 0, 9);
    send(4'b0001, 4'd10);
    expect_resp("rg_free", QEN ? 2'b10 : 2'b01, 0, 10);
    repeat (50) tick();

    // Early release
    send(4'b0010, 4'd9);
    expect_resp("rel_grant", 2'b01, 1, 9);
    repeat (2) tick();
    doc_release = 4'b0010;
    tick();
    doc_release = '0;
    chk("rel_busy", busy, 4'b0000);
    tick();
    send(4'b0010, 4'd10);
    expect_resp("rel_regrant", 2'b01, 1, 10);
    doc_release = 4'b0100;
    send(4'b0100, 4'd11);
    doc_release = '0;
    expect_resp("rel_cycle", ST_MISS, 0, 11);
    chk("rel_idle_busy", busy, 4'b0010);
    repeat (20) tick();

`ifdef WAIT_QUEUE_EN
    // Queue service order and spacing
    send(4'b0001, 4'd0);
    expect_resp("q_hold", 2'b01, 0, 0);
    send(4'b0001, 4'd1);
    expect_resp("q_t1", 2'b10, 0, 1);
    send(4'b0001, 4'd2);
    expect_resp("q_t2", 2'b10, 0, 2);
    chk("q_count2", q_count, 2);
    wait_alloc(n);
    chk("q_alloc1_tag", alloc_tag, 1);
    chk("q_alloc1_doc", alloc_doc, 0);
    tick();
    wait_alloc(n);
    // 15 busy cycles, then the head is granted on the edge busy reads 0
    chk("q_alloc_gap", n + 1, 16);
    chk("q_alloc2_tag", alloc_tag, 2);
    // Fill the queue and hold a fifth request off
    for (int t = 3; t < 7; t++) begin
      send(4'b0001, TAG_W'(t));
      chk("q_fill_status", resp_status, 2'b10);
    end
    chk("q_full_count", q_count, 4);
    chk("q_full_ready", req_ready, 0);
    req_valid = 1'b1; req_mask = 4'b0001; req_tag = 4'd7;
    repeat (3) begin
      tick();
      chk("q_held_resp", resp_valid, 0);
    end
    req_valid = 1'b0; req_mask = '0; req_tag = '0;
`else
    send(4'b1000, 4'd12);
    expect_resp("pre_reset", 2'b01, 3, 12);
    repeat (3) tick();
`endif

    // Asynchronous reset mid-consultation
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_qcount", q_count, 0);
    chk("arst_resp", resp_valid, 0);
    chk("arst_ready", req_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", req_ready, 1);
    send(4'b0001, 4'd13);
    expect_resp("post_reset", 2'b01, 0, 13);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
